// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with a start/busy/done handshake: one sum bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add a registered two's-complement overflow output (ovf).
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      full_add = {(a & b) | ((a ^ b) & c), a ^ b ^ c};
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [1:0]       fa;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      fa      = full_add(a_q[0], b_q[0], carry_q);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = cin;
               cnt_d   = '0;
               psum_d  = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa[1];
            psum_d  = {fa[0], psum_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               // On the MSB step carry_q is the carry into the MSB, fa[1] the carry out.
               s_d     = {fa[0], psum_q[WIDTH-1:1]};
               cout_d  = fa[1];
               ovf_d   = carry_q ^ fa[1];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign S    = s_q;
   assign Cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected sums queued at start, checked at each done pulse.
module tb_serial_adder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A, B;
   logic         cin;
   logic         busy, done;
   logic [W-1:0] S;
   logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (A),
      .B    (B),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .S    (S),
      .Cout (Cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           starts = 0;
   int           dones = 0;
   logic         mon_en = 1'b0;
   logic [W:0]   held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t       e;
      logic [W:0] sum;
      int         n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      if (busy) chk("issue_timeout", 32'd1, 32'd0);
      A     = a;
      B     = b;
      cin   = c;
      start = 1'b1;
      sum    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.s    = sum[W-1:0];
      e.cout = sum[W];
      e.ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      e.acc  = cyc + 1;
      sb.push_back(e);
      starts++;
      step();
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         step();
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy_done_excl", 32'(busy & done), 32'd0);
         if (!rst_n) begin
            held = '0;
         end else if (done) begin
            dones++;
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sum", 32'(S), 32'(e.s));
               chk("cout", 32'(Cout), 32'(e.cout));
               chk("latency", 32'(cyc - e.acc), 32'(W));
`ifdef SERIAL_ADDER_OVF_EN
               chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
               held = {e.cout, e.s};
            end
         end else begin
            chk("hold", 32'({Cout, S}), 32'(held));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      cin = 1'b0;
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(S), 32'd0);
      chk("rst_cout", 32'(Cout), 32'd0);
      mon_en = 1'b1;
      rst_n = 1'b1;
      step();

      issue(4'h5, 4'h3, 1'b0);
      drain();
      repeat (10) step();
      chk("s_held_10", 32'(S), 32'h8);
      chk("cout_held_10", 32'(Cout), 32'h0);

      issue(4'hF, 4'h1, 1'b0);
      issue(4'hF, 4'hF, 1'b1);
      drain();

      issue(4'h2, 4'h2, 1'b0);
      A = 4'hF; B = 4'hF; start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      drain();
      chk("ignored_start_s", 32'(S), 32'h4);

      issue(4'h9, 4'h6, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      starts--;
      d0 = dones;
      step();
      rst_n = 1'b1;
      chk("midrun_rst_busy", 32'(busy), 32'd0);
      chk("midrun_rst_done", 32'(done), 32'd0);
      chk("midrun_rst_s", 32'(S), 32'd0);
      chk("midrun_rst_cout", 32'(Cout), 32'd0);
      repeat (8) step();
      chk("no_done_after_rst", 32'(dones), 32'(d0));
      issue(4'h1, 4'h1, 1'b0);
      drain();
      chk("after_rst_s", 32'(S), 32'h2);

      issue(4'h7, 4'h1, 1'b0);
      issue(4'h8, 4'h8, 1'b0);
      issue(4'h3, 4'h2, 1'b0);
      drain();

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               issue(W'(a), W'(b), c[0]);
      drain();
      step();
      chk("done_count", 32'(dones), 32'(starts));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
